// File: rtl/reg_wb_buffer.sv
// reg_wb_buffer: circular write-back buffer between a producer and the
// register-file write port. Writes drain in acceptance order, one per cycle,
// unless hold is asserted. Pending writes can be forwarded to two read ports.
// Optional feature: define REG_WB_BUFFER_BYPASS_EN to build the forwarding
// comparators. Without it the bypass outputs are tied to zero.
module reg_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rs,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_data,
  input  logic                   hold,
  output logic                   rf_en,
  output logic [AW-1:0]          rf_addr,
  output logic [DW-1:0]          rf_data,
  input  logic [AW-1:0]          rd_addr0,
  input  logic [AW-1:0]          rd_addr1,
  output logic                   byp_hit0,
  output logic                   byp_hit1,
  output logic [DW-1:0]          byp_data0,
  output logic [DW-1:0]          byp_data1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          pushEn;
  logic          popEn;

  // Handshake and drain control; all outputs are quiet while reset is held,
  // and register index 0 is accepted but never stored.
  always_comb begin
    in_ready = !rs || (count_q < CW'(DEPTH));
    rf_en    = rs && (count_q != '0) && !hold;
    pushEn   = rs && in_valid && (count_q < CW'(DEPTH)) && (in_addr != '0);
    popEn    = rf_en;
    rf_addr  = addr_q[head_q];
    rf_data  = data_q[head_q];
    count    = count_q;
  end

  // Next-state pointers and occupancy; a push and a pop together cancel out.
  always_comb begin
    head_d  = popEn  ? head_q + PW'(1) : head_q;
    tail_d  = pushEn ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(pushEn) - CW'(popEn);
  end

  // Pointer and occupancy registers; reset wins over any push or pop.
  always_ff @(posedge clk) begin
    if (!rs) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at the tail; contents need no reset because
  // occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

`ifdef REG_WB_BUFFER_BYPASS_EN
  logic [PW-1:0] scanIdx;

  // Scan live entries oldest to youngest so the last match (nearest the
  // tail) wins; the head stays visible in the cycle it drains and the
  // request being pushed this cycle is not yet in storage.
  always_comb begin
    byp_hit0  = 1'b0;
    byp_hit1  = 1'b0;
    byp_data0 = '0;
    byp_data1 = '0;
    scanIdx   = '0;
    if (rs) begin
      for (int i = 0; i < DEPTH; i++) begin
        scanIdx = head_q + PW'(i);
        if (CW'(i) < count_q) begin
          if ((rd_addr0 != '0) && (addr_q[scanIdx] == rd_addr0)) begin
            byp_hit0  = 1'b1;
            byp_data0 = data_q[scanIdx];
          end
          if ((rd_addr1 != '0) && (addr_q[scanIdx] == rd_addr1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = data_q[scanIdx];
          end
        end
      end
    end
  end
`else
  logic unusedRdAddr;

  // Forwarding is not built: the read indices are ignored and no hit is
  // ever reported.
  always_comb begin
    byp_hit0     = 1'b0;
    byp_hit1     = 1'b0;
    byp_data0    = '0;
    byp_data1    = '0;
    unusedRdAddr = ^{rd_addr0, rd_addr1};
  end
`endif

endmodule

// File: tb/tb_reg_wb_buffer.sv
// tb_reg_wb_buffer: directed scenarios for reg_wb_buffer. Accepted writes
// are queued as expected register-file writes; a monitor pops and compares
// whenever rf_en is seen. Bypass expectations follow REG_WB_BUFFER_BYPASS_EN.
module tb_reg_wb_buffer;

`ifdef REG_WB_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rs;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic        rf_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  rd_addr0, rd_addr1;
  logic        byp_hit0, byp_hit1;
  logic [31:0] byp_data0, byp_data1;
  logic [2:0]  count;

  int  checks = 0;
  int  errors = 0;
  wr_t expQ[$];
  wr_t monEntry;

  reg_wb_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rs(rs), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold),
    .rf_en(rf_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .byp_hit0(byp_hit0), .byp_hit1(byp_hit1),
    .byp_data0(byp_data0), .byp_data1(byp_data1),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and wait (bounded) for the handshake; accepted
  // non-zero writes become expected register-file writes.
  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    int  waited = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        if (a != 5'd0) expQ.push_back('{a: a, d: d});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 20) begin
          checks++;
          errors++;
          $display("[TB] FAIL handshake timeout: addr %0h never accepted", a);
          done = 1'b1;
        end
        @(posedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rf_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected write: got addr %0h data %0h, required no write", rf_addr, rf_data);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("rf_addr order", 32'(rf_addr), 32'(monEntry.a));
        checkOutput("rf_data order", rf_data, monEntry.d);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic rdy;
    rs = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; hold = 1'b0;
    rd_addr0 = 5'd3; rd_addr1 = 5'd4;
    repeat (2) tick();
    checkOutput("reset in_ready", 32'(in_ready), 1);
    checkOutput("reset rf_en", 32'(rf_en), 0);
    checkOutput("reset count", 32'(count), 0);
    checkOutput("reset byp_hit0", 32'(byp_hit0), 0);
    checkOutput("reset byp_hit1", 32'(byp_hit1), 0);
    checkOutput("reset byp_data0", byp_data0, 0);
    rs = 1'b1;
    rd_addr0 = '0; rd_addr1 = '0;
    tick();

    $display("[TB] single write");
    applyStimulus(5'd3, 32'hFFFF_FFFF);
    checkOutput("single rf_en", 32'(rf_en), 1);
    checkOutput("single rf_addr", 32'(rf_addr), 3);
    checkOutput("single rf_data", rf_data, 32'hFFFF_FFFF);
    checkOutput("single count", 32'(count), 1);
    tick();
    checkOutput("single drained count", 32'(count), 0);
    checkOutput("single drained rf_en", 32'(rf_en), 0);

    $display("[TB] full buffer");
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(5'(i), 32'h1000_0000 + 32'(i));
    checkOutput("full in_ready", 32'(in_ready), 0);
    checkOutput("full count", 32'(count), 4);
    checkOutput("full rf_en under hold", 32'(rf_en), 0);
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h77;
    repeat (3) tick();
    checkOutput("fifth stalls count", 32'(count), 4);
    checkOutput("fifth stalls in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checkOutput("full drain rf_en", 32'(rf_en), 1);
      checkOutput("full drain rf_addr", 32'(rf_addr), k);
      tick();
    end
    checkOutput("full drained count", 32'(count), 0);

    $display("[TB] forwarding");
    hold = 1'b1;
    rd_addr0 = 5'd12;
    in_valid = 1'b1; in_addr = 5'd12; in_data = 32'h0000_000C;
    @(negedge clk);
    checkOutput("push not forwarded", 32'(byp_hit0), 0);
    checkOutput("empty in_ready", 32'(in_ready), 1);
    @(posedge clk);
    expQ.push_back('{a: 5'd12, d: 32'h0000_000C});
    #1;
    in_valid = 1'b0;
    checkOutput("fwd single hit", 32'(byp_hit0), 32'(BYP));
    checkOutput("fwd single data", byp_data0, BYP ? 32'h0000_000C : 32'h0);
    applyStimulus(5'd5, 32'hAAAA_0001);
    applyStimulus(5'd5, 32'hBBBB_0002);
    rd_addr0 = 5'd5; rd_addr1 = 5'd6;
    #1;
    checkOutput("fwd youngest hit0", 32'(byp_hit0), 32'(BYP));
    checkOutput("fwd youngest data0", byp_data0, BYP ? 32'hBBBB_0002 : 32'h0);
    checkOutput("fwd miss hit1", 32'(byp_hit1), 0);
    checkOutput("fwd miss data1", byp_data1, 0);
    rd_addr0 = 5'd12;
    hold = 1'b0;
    #1;
    checkOutput("fwd draining head hit", 32'(byp_hit0), 32'(BYP));
    checkOutput("fwd draining head data", byp_data0, BYP ? 32'h0000_000C : 32'h0);
    repeat (3) tick();
    checkOutput("fwd drained count", 32'(count), 0);
    checkOutput("fwd drained hit0", 32'(byp_hit0), 0);
    rd_addr0 = '0; rd_addr1 = '0;

    $display("[TB] zero register");
    applyStimulus(5'd0, 32'hDEAD_BEEF);
    checkOutput("zero count", 32'(count), 0);
    checkOutput("zero rf_en", 32'(rf_en), 0);
    #1;
    checkOutput("zero byp_hit0", 32'(byp_hit0), 0);

    $display("[TB] concurrent push/pop");
    hold = 1'b1;
    applyStimulus(5'd10, 32'h5000_00A0);
    applyStimulus(5'd11, 32'h5000_00B0);
    hold = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_addr = 5'(12 + k);
      in_data = 32'h5000_0000 + 32'(k);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) expQ.push_back('{a: 5'(12 + k), d: 32'h5000_0000 + 32'(k)});
      #1;
      checkOutput("concurrent count", 32'(count), 2);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("concurrent drained count", 32'(count), 0);

    $display("[TB] mid-operation reset");
    hold = 1'b1;
    applyStimulus(5'd20, 32'h2000_0020);
    applyStimulus(5'd21, 32'h2000_0021);
    applyStimulus(5'd22, 32'h2000_0022);
    checkOutput("pre-reset count", 32'(count), 3);
    rs = 1'b0;
    hold = 1'b0;
    expQ.delete();
    #1;
    checkOutput("in reset rf_en", 32'(rf_en), 0);
    checkOutput("in reset in_ready", 32'(in_ready), 1);
    tick();
    rs = 1'b1;
    #1;
    checkOutput("post reset count", 32'(count), 0);
    checkOutput("post reset rf_en", 32'(rf_en), 0);
    checkOutput("post reset in_ready", 32'(in_ready), 1);
    repeat (4) tick();
    applyStimulus(5'd8, 32'h8888_0008);
    repeat (2) tick();

    checkOutput("scoreboard drained", 32'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_buffer.md
REG_WB_BUFFER -- requirements
Module: reg_wb_buffer

Interface
REQ-001 Parameter DEPTH, 4, number of buffered write entries (power of two, 2..16).
REQ-002 Parameter AW, 5, register address width.
REQ-003 Parameter DW, 32, register data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rs  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  write request present.
REQ-007 in_ready  output  1  buffer can accept a request this cycle.
REQ-008 in_addr  input  AW  destination register index.
REQ-009 in_data  input  DW  write data.
REQ-010 hold  input  1  pauses draining toward the register file.
REQ-011 rf_en  output  1  write enable to the register block write port.
REQ-012 rf_addr  output  AW  write index to the register block.
REQ-013 rf_data  output  DW  write data to the register block.
REQ-014 rd_addr0, rd_addr1  input  AW each  register block read indices, snooped for bypass.
REQ-015 byp_hit0, byp_hit1  output  1 each  a pending buffered write matches the read index.
REQ-016 byp_data0, byp_data1  output  DW each  forwarded data for a hit.
REQ-017 count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 The buffer SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-019 in_ready SHALL equal (count < DEPTH), registered-state only, with no combinational dependence on hold.
REQ-020 A push SHALL occur on an edge where in_valid && in_ready && in_addr != 0.
REQ-021 A request with in_addr == 0 SHALL be accepted (handshake completes) and discarded without an entry.
REQ-022 rf_en SHALL equal (count != 0) && !hold; rf_addr and rf_data SHALL present the head entry combinationally.
REQ-023 A pop SHALL occur on every edge where rf_en is 1, so at most one entry drains per cycle.
REQ-024 Latency: a request accepted at edge N into an empty buffer SHALL drive rf_en in the cycle after edge N, provided hold is 0.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; with count == DEPTH, no push occurs, because in_ready is 0.
REQ-026 With count == 0, rf_en SHALL be 0, and rf_addr and rf_data SHALL be don't-care.
REQ-027 Bypass: byp_hitK SHALL be 1 when any occupied entry has addr == rd_addrK and rd_addrK != 0.
REQ-028 byp_dataK SHALL be the data of the youngest matching entry (the one nearest the tail), and SHALL be 0 when there is no hit.
REQ-029 Bypass SHALL include the head entry in the cycle it drains, and SHALL exclude the request being pushed in that same cycle.
REQ-030 Write order to the register file SHALL equal acceptance order.

Reset
REQ-031 When rs == 0 at an edge, head, tail and count SHALL reset to 0, discarding all pending entries.
REQ-032 During reset and after it: in_ready = 1, rf_en = 0, byp_hit0 = byp_hit1 = 0, byp_data0 = byp_data1 = 0.
REQ-033 Reset SHALL take priority over a push or pop on the same edge; entry storage need not be cleared.

Configuration
REQ-034 Macro REG_WB_BUFFER_BYPASS_EN defined: the bypass logic of REQ-027 to REQ-029 SHALL be compiled in.
REQ-035 Macro REG_WB_BUFFER_BYPASS_EN undefined: byp_hit0/1 SHALL be tied to 0 and byp_data0/1 to 0, with no comparator logic; all other behaviour is unchanged.

Verification
REQ-036 Scenario, single write: reset, then push addr 3 / data 32'hFFFFFFFF with hold = 0 -> the next cycle shows rf_en = 1, rf_addr = 3, rf_data = FFFFFFFF; the following cycle shows count = 0.
REQ-037 Scenario, full: hold = 1 and push 4 entries (addr 1..4) -> in_ready = 0 and count = 4; a fifth request stalls. Release hold -> rf_addr shows 1, 2, 3, 4 on consecutive cycles.
REQ-038 Scenario, forwarding: hold = 1, push addr 5 data A, then addr 5 data B; rd_addr0 = 5 -> byp_hit0 = 1 and byp_data0 = B. rd_addr1 = 6 -> byp_hit1 = 0 and byp_data1 = 0 (with REG_WB_BUFFER_BYPASS_EN defined; without it, both hits are 0).
REQ-039 Scenario, zero register: push addr 0 -> the handshake completes, count stays 0, rf_en stays 0; rd_addr0 = 0 -> byp_hit0 = 0.
REQ-040 Scenario, concurrent push/pop: count = 2, hold = 0 and in_valid = 1 each cycle for 10 cycles -> count stays 2 and order is preserved, exercising pointer wrap-around.
REQ-041 Scenario, mid-operation reset: count = 3, then rs = 0 for one edge -> count = 0, rf_en = 0, in_ready = 1 on the next cycle; no stale entry is ever written.
